wr_recovery_ctrl: RTL and testbench
===================================

WR_RECOVERY_CTRL -- requirements
Module: wr_recovery_ctrl

Interface
REQ-001 Parameter HoldWidth, default 8: width of the slave-reset hold-count input.
REQ-002 Parameter DrainMax, default 256: maximum ISOLATE cycles spent waiting for drain.
REQ-003 Parameter SettleCycles, default 4: post-reset settle cycles; legal range >=1.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk_i  in  1  clock; all state updates on the rising edge.
REQ-006 rst_ni  in  1  asynchronous, active-low reset.
REQ-007 reset_req_i  in  1  reset request from the write transaction manager.
REQ-008 timeout_i  in  1  budget-violation flag from the write transaction manager.
REQ-009 outstanding_i  in  1  a master-side AW/W/B handshake is in flight.
REQ-010 hold_cycles_i  in  HoldWidth  slave-reset hold length, from the register file.
REQ-011 irq_clr_i  in  1  software acknowledge; clears the sticky flags.
REQ-012 isolate_o  out  1  gate new master requests and force ready low toward the master.
REQ-013 slv_rst_no  out  1  active-low reset to the guarded slave.
REQ-014 flush_o  out  1  one-cycle pulse that clears the linked-data and head/tail tables (drives rd_rst_i).
REQ-015 busy_o  out  1  FSM is not in IDLE.
REQ-016 irq_o  out  1  sticky recovery interrupt.
REQ-017 drain_forced_o  out  1  sticky flag: drain timed out.
REQ-018 recovery_cnt_o  out  8  saturating count of started recoveries.

Function
REQ-019 FSM states: IDLE, ISOLATE, FLUSH, HOLD, SETTLE. All outputs are decoded from registered state (Moore); there are no combinational input-to-output paths.
REQ-020 Trigger: (reset_req_i | timeout_i) sampled high in IDLE at edge t -> ISOLATE from cycle t+1.
REQ-021 Triggers arriving in any state other than IDLE are ignored; they are not queued.
REQ-022 ISOLATE behaviour:
- outstanding_i low -> FLUSH next cycle.
- otherwise the drain counter increments.
- after DrainMax cycles in ISOLATE -> FLUSH, and drain_forced_o is set.
REQ-023 FLUSH lasts exactly one cycle, with flush_o=1; it then goes to HOLD.
REQ-024 On the FLUSH->HOLD edge, hold_cycles_i is latched. A latched value of 0 is treated as 1.
REQ-025 HOLD: slv_rst_no=0 for exactly the latched count of cycles; it then goes to SETTLE. Changes to hold_cycles_i during HOLD have no effect.
REQ-026 SETTLE: slv_rst_no=1 and isolate_o=1 for SettleCycles cycles; it then returns to IDLE.
REQ-027 isolate_o=1 in ISOLATE, FLUSH, HOLD and SETTLE; 0 in IDLE.
REQ-028 busy_o=1 in every state except IDLE.
REQ-029 slv_rst_no=0 only in HOLD.
REQ-030 irq_o is set on the IDLE->ISOLATE transition.
REQ-031 irq_o and drain_forced_o are cleared by irq_clr_i. If set and clear occur in the same cycle, set wins.
REQ-032 recovery_cnt_o increments on each IDLE->ISOLATE transition and saturates at 255; irq_clr_i does not clear it.
REQ-033 Counter widths:
- drain counter: $clog2(DrainMax+1) bits.
- settle counter: $clog2(SettleCycles+1) bits.
- hold counter: HoldWidth bits; it counts down and leaves HOLD when it reaches 1.
REQ-034 Minimum recovery length with outstanding_i=0: 1 (ISOLATE) + 1 (FLUSH) + hold + SettleCycles cycles.

Reset
REQ-035 rst_ni low at any time, including mid-recovery, forces the following asynchronously:
- state=IDLE, with all counters 0.
- isolate_o=0, slv_rst_no=1, flush_o=0, busy_o=0.
- irq_o=0, drain_forced_o=0, recovery_cnt_o=0.
REQ-036 After rst_ni deasserts, the first trigger is accepted on the first rising edge.

Verification
REQ-037 Nominal path: reset_req_i pulsed 1 cycle at t, outstanding_i=0, hold_cycles_i=3, SettleCycles=4 -> required response:
- isolate_o high t+1..t+9.
- flush_o high t+2 only.
- slv_rst_no low t+3..t+5.
- busy_o low at t+10.
- irq_o=1; recovery_cnt_o=1.
REQ-038 Drain timeout: trigger while outstanding_i is held high, DrainMax=8 -> FLUSH entered after 8 ISOLATE cycles; drain_forced_o=1.
REQ-039 Zero hold and re-trigger: hold_cycles_i=0 -> slv_rst_no low for exactly 1 cycle; a second timeout_i pulse during HOLD -> ignored, recovery_cnt_o stays 1.
REQ-040 Interrupt race and saturation:
- irq_clr_i in the same cycle as a new IDLE trigger -> irq_o remains 1.
- 300 recoveries -> recovery_cnt_o=255.
REQ-041 Mid-recovery reset: rst_ni asserted during HOLD -> in the same cycle, slv_rst_no=1, isolate_o=0, irq_o=0, recovery_cnt_o=0.

Source files
------------

// File: rtl/wr_recovery_ctrl_if.sv
// Control/status bundle between the write transaction manager, register file
// and the write recovery controller.
interface wr_recovery_ctrl_if #(
  parameter int unsigned HoldWidth = 8
);
  logic                 reset_req_i;
  logic                 timeout_i;
  logic                 outstanding_i;
  logic [HoldWidth-1:0] hold_cycles_i;
  logic                 irq_clr_i;
  logic                 isolate_o;
  logic                 slv_rst_no;
  logic                 flush_o;
  logic                 busy_o;
  logic                 irq_o;
  logic                 drain_forced_o;
  logic [7:0]           recovery_cnt_o;

  modport master (
    output reset_req_i, timeout_i, outstanding_i, hold_cycles_i, irq_clr_i,
    input  isolate_o, slv_rst_no, flush_o, busy_o, irq_o, drain_forced_o,
           recovery_cnt_o
  );

  modport slave (
    input  reset_req_i, timeout_i, outstanding_i, hold_cycles_i, irq_clr_i,
    output isolate_o, slv_rst_no, flush_o, busy_o, irq_o, drain_forced_o,
           recovery_cnt_o
  );
endinterface

// File: rtl/wr_recovery_ctrl.sv
// Write-path recovery sequencer: isolate the master, drain, flush tables,
// hold the slave in reset, settle, then resume. Moore outputs only.
module wr_recovery_ctrl #(
  parameter int unsigned HoldWidth    = 8,
  parameter int unsigned DrainMax     = 256,
  parameter int unsigned SettleCycles = 4
) (
  input logic               clk_i,
  input logic               rst_ni,
  wr_recovery_ctrl_if.slave bus
);

  localparam int unsigned DrainW  = $clog2(DrainMax + 1);
  localparam int unsigned SettleW = $clog2(SettleCycles + 1);

  localparam logic [DrainW-1:0]  DrainLast  = DrainW'(DrainMax - 1);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SettleCycles - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISOLATE,
    FLUSH,
    HOLD,
    SETTLE
  } state_t;

  state_t               state_q, state_d;
  logic [DrainW-1:0]    drain_cnt_q;
  logic [SettleW-1:0]   settle_cnt_q;
  logic [HoldWidth-1:0] hold_cnt_q;
  logic                 irq_q;
  logic                 drain_forced_q;
  logic [7:0]           recovery_cnt_q;
  logic                 start;
  logic                 forced;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    forced  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.reset_req_i || bus.timeout_i) begin
          state_d = ISOLATE;
          start   = 1'b1;
        end
      end
      ISOLATE: begin
        if (!bus.outstanding_i) begin
          state_d = FLUSH;
        end else if (drain_cnt_q == DrainLast) begin
          state_d = FLUSH;
          forced  = 1'b1;
        end
      end
      FLUSH:   state_d = HOLD;
      HOLD: begin
        if (hold_cnt_q == HoldWidth'(1)) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == SettleLast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Each counter runs only while its state persists and clears otherwise, so
  // every visit to a state starts from a known value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drain_cnt_q  <= '0;
      settle_cnt_q <= '0;
      hold_cnt_q   <= '0;
    end else begin
      if (state_q == ISOLATE && state_d == ISOLATE) begin
        drain_cnt_q <= drain_cnt_q + DrainW'(1);
      end else begin
        drain_cnt_q <= '0;
      end

      if (state_q == SETTLE && state_d == SETTLE) begin
        settle_cnt_q <= settle_cnt_q + SettleW'(1);
      end else begin
        settle_cnt_q <= '0;
      end

      if (state_q == FLUSH) begin
        hold_cnt_q <= (bus.hold_cycles_i == '0) ? HoldWidth'(1) : bus.hold_cycles_i;
      end else if (state_q == HOLD && state_d == HOLD) begin
        hold_cnt_q <= hold_cnt_q - HoldWidth'(1);
      end else if (state_q != HOLD) begin
        hold_cnt_q <= '0;
      end
    end
  end

  // Set takes priority over software clear on the sticky flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q          <= 1'b0;
      drain_forced_q <= 1'b0;
      recovery_cnt_q <= '0;
    end else begin
      if (start) begin
        irq_q <= 1'b1;
      end else if (bus.irq_clr_i) begin
        irq_q <= 1'b0;
      end

      if (forced) begin
        drain_forced_q <= 1'b1;
      end else if (bus.irq_clr_i) begin
        drain_forced_q <= 1'b0;
      end

      if (start && recovery_cnt_q != '1) begin
        recovery_cnt_q <= recovery_cnt_q + 8'd1;
      end
    end
  end

  assign bus.isolate_o      = (state_q != IDLE);
  assign bus.busy_o         = (state_q != IDLE);
  assign bus.flush_o        = (state_q == FLUSH);
  assign bus.slv_rst_no     = (state_q != HOLD);
  assign bus.irq_o          = irq_q;
  assign bus.drain_forced_o = drain_forced_q;
  assign bus.recovery_cnt_o = recovery_cnt_q;

endmodule

// File: tb/tb_wr_recovery_ctrl.sv
// Directed vector bench for wr_recovery_ctrl (DrainMax=8, SettleCycles=4).
module tb_wr_recovery_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  wr_recovery_ctrl_if #(.HoldWidth(8)) bus ();

  wr_recovery_ctrl #(
    .HoldWidth   (8),
    .DrainMax    (8),
    .SettleCycles(4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // st: "I" idle, "S" isolate, "F" flush, "H" hold, "T" settle (state after the edge)
  typedef struct {
    logic       rr;
    logic       to;
    logic       os;
    logic [7:0] hold;
    logic       clr;
    byte        st;
    logic       irq;
    logic       df;
    logic [7:0] cnt;
  } vec_t;

  localparam int NV = 35;
  vec_t vecs[NV];

  function automatic vec_t v(input logic rr, input logic to, input logic os,
                             input logic [7:0] hold, input logic clr, input byte st,
                             input logic irq, input logic df, input logic [7:0] cnt);
    vec_t r;
    r.rr = rr; r.to = to; r.os = os; r.hold = hold; r.clr = clr;
    r.st = st; r.irq = irq; r.df = df; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input byte st, input logic irq,
                          input logic df, input logic [7:0] cnt);
    chk({nm, " isolate"}, int'(bus.isolate_o), int'(st != "I"));
    chk({nm, " slv_rst_n"}, int'(bus.slv_rst_no), int'(st != "H"));
    chk({nm, " flush"}, int'(bus.flush_o), int'(st == "F"));
    chk({nm, " busy"}, int'(bus.busy_o), int'(st != "I"));
    chk({nm, " irq"}, int'(bus.irq_o), int'(irq));
    chk({nm, " drain_forced"}, int'(bus.drain_forced_o), int'(df));
    chk({nm, " cnt"}, int'(bus.recovery_cnt_o), int'(cnt));
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (bus.busy_o && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " idle_timeout"}, int'(bus.busy_o), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    // nominal: hold=3, hold input changed during HOLD has no effect
    vecs[0]  = v(1, 0, 0, 3, 0, "S", 1, 0, 1);
    vecs[1]  = v(0, 0, 0, 3, 0, "F", 1, 0, 1);
    vecs[2]  = v(0, 0, 0, 3, 0, "H", 1, 0, 1);
    vecs[3]  = v(0, 0, 0, 7, 0, "H", 1, 0, 1);
    vecs[4]  = v(0, 0, 0, 7, 0, "H", 1, 0, 1);
    vecs[5]  = v(0, 0, 0, 7, 0, "T", 1, 0, 1);
    vecs[6]  = v(0, 0, 0, 7, 0, "T", 1, 0, 1);
    vecs[7]  = v(0, 0, 0, 7, 0, "T", 1, 0, 1);
    vecs[8]  = v(0, 0, 0, 7, 0, "T", 1, 0, 1);
    vecs[9]  = v(0, 0, 0, 0, 0, "I", 1, 0, 1);
    // drain timeout: 8 ISOLATE cycles, then forced FLUSH; zero hold; ignored timeout
    vecs[10] = v(0, 1, 1, 0, 0, "S", 1, 0, 2);
    vecs[11] = v(0, 0, 1, 0, 0, "S", 1, 0, 2);
    vecs[12] = v(0, 0, 1, 0, 0, "S", 1, 0, 2);
    vecs[13] = v(0, 0, 1, 0, 0, "S", 1, 0, 2);
    vecs[14] = v(0, 0, 1, 0, 0, "S", 1, 0, 2);
    vecs[15] = v(0, 0, 1, 0, 0, "S", 1, 0, 2);
    vecs[16] = v(0, 0, 1, 0, 0, "S", 1, 0, 2);
    vecs[17] = v(0, 0, 1, 0, 0, "S", 1, 0, 2);
    vecs[18] = v(0, 0, 1, 0, 0, "F", 1, 1, 2);
    vecs[19] = v(0, 0, 0, 0, 0, "H", 1, 1, 2);
    vecs[20] = v(0, 1, 0, 0, 0, "T", 1, 1, 2);
    vecs[21] = v(0, 0, 0, 0, 0, "T", 1, 1, 2);
    vecs[22] = v(0, 0, 0, 0, 0, "T", 1, 1, 2);
    vecs[23] = v(0, 0, 0, 0, 0, "T", 1, 1, 2);
    vecs[24] = v(0, 0, 0, 0, 0, "I", 1, 1, 2);
    // clear, then clear racing a new trigger; trigger during SETTLE ignored
    vecs[25] = v(0, 0, 0, 0, 1, "I", 0, 0, 2);
    vecs[26] = v(1, 0, 0, 2, 1, "S", 1, 0, 3);
    vecs[27] = v(0, 0, 0, 2, 0, "F", 1, 0, 3);
    vecs[28] = v(0, 0, 0, 2, 0, "H", 1, 0, 3);
    vecs[29] = v(0, 0, 0, 2, 0, "H", 1, 0, 3);
    vecs[30] = v(0, 0, 0, 2, 0, "T", 1, 0, 3);
    vecs[31] = v(1, 1, 0, 2, 0, "T", 1, 0, 3);
    vecs[32] = v(0, 0, 0, 2, 0, "T", 1, 0, 3);
    vecs[33] = v(0, 0, 0, 2, 0, "T", 1, 0, 3);
    vecs[34] = v(0, 0, 0, 2, 0, "I", 1, 0, 3);

    rst_n             = 1'b0;
    bus.reset_req_i   = 1'b0;
    bus.timeout_i     = 1'b0;
    bus.outstanding_i = 1'b0;
    bus.hold_cycles_i = '0;
    bus.irq_clr_i     = 1'b0;
    #3;
    chk_outs("reset", "I", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      bus.reset_req_i   = vecs[i].rr;
      bus.timeout_i     = vecs[i].to;
      bus.outstanding_i = vecs[i].os;
      bus.hold_cycles_i = vecs[i].hold;
      bus.irq_clr_i     = vecs[i].clr;
      @(posedge clk); #1;
      chk_outs($sformatf("row%0d", i), vecs[i].st, vecs[i].irq, vecs[i].df, vecs[i].cnt);
    end
    bus.reset_req_i   = 1'b0;
    bus.timeout_i     = 1'b0;
    bus.outstanding_i = 1'b0;
    bus.irq_clr_i     = 1'b0;

    // asynchronous reset while in HOLD
    bus.reset_req_i   = 1'b1;
    bus.hold_cycles_i = 8'd5;
    @(posedge clk); #1;
    bus.reset_req_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_outs("pre_rst_hold", "H", 1, 0, 4);
    #3;
    rst_n = 1'b0;
    #1;
    chk_outs("mid_rst", "I", 0, 0, 0);

    // first edge after reset release accepts a trigger
    @(negedge clk);
    rst_n             = 1'b1;
    bus.reset_req_i   = 1'b1;
    bus.hold_cycles_i = 8'd1;
    @(posedge clk); #1;
    bus.reset_req_i = 1'b0;
    chk_outs("first_edge", "S", 1, 0, 1);
    wait_idle("rec1");

    // 299 more recoveries saturate the counter at 255
    for (int k = 0; k < 299; k++) begin
      bus.reset_req_i = 1'b1;
      @(posedge clk); #1;
      bus.reset_req_i = 1'b0;
      wait_idle($sformatf("sat%0d", k));
    end
    chk("sat_cnt", int'(bus.recovery_cnt_o), 255);
    chk("sat_irq", int'(bus.irq_o), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
